// File: rtl/split_buf.sv
// split_buf: routes each payload token to output FIFO A or B, as chosen by a paired select token.
// Optional macro SPLIT_CNT_EN adds the 16-bit delivered-token counters cnt_a/cnt_b.
module split_buf #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data
`ifdef SPLIT_CNT_EN
    ,
    output logic [15:0]      cnt_a,
    output logic [15:0]      cnt_b
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {SEL, DATA} state_t;

    state_t           state, state_nx;
    logic             sel_q, sel_nx;
    logic             xfer_s, xfer_d;
    logic [1:0]       full, vld, push, pop;
    logic [WIDTH-1:0] mem [2][DEPTH];
    logic [AW-1:0]    wp [2];
    logic [AW-1:0]    rp [2];
    logic [AW:0]      occ [2];

    // Readiness looks only at registered occupancy, so a pop never frees a slot in the same cycle.
    always_comb begin
        full     = {occ[1] == (AW+1)'(DEPTH), occ[0] == (AW+1)'(DEPTH)};
        vld      = {occ[1] != '0, occ[0] != '0};
        pop      = vld & {b_ready, a_ready};
        in_ready = (state == DATA) && !full[sel_q];
        s_ready  = (state == SEL) || (in_valid && in_ready);
        xfer_d   = in_valid && in_ready;
        xfer_s   = s_valid && s_ready;
        push     = xfer_d ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
        state_nx = xfer_s ? DATA : (xfer_d ? SEL : state);
        sel_nx   = xfer_s ? s_sel : sel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEL;
            sel_q <= 1'b0;
        end else begin
            state <= state_nx;
            sel_q <= sel_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                wp[i]  <= '0;
                rp[i]  <= '0;
                occ[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wp[i] <= wp[i] + 1'b1;
                if (pop[i]) rp[i] <= rp[i] + 1'b1;
                occ[i] <= occ[i] + {{AW{1'b0}}, push[i]} - {{AW{1'b0}}, pop[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (push[i]) mem[i][wp[i]] <= in_data;
    end

    assign a_valid = vld[0];
    assign b_valid = vld[1];
    assign a_data  = vld[0] ? mem[0][rp[0]] : '0;
    assign b_data  = vld[1] ? mem[1][rp[1]] : '0;

`ifdef SPLIT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            cnt_a <= cnt_a + {15'd0, pop[0]};
            cnt_b <= cnt_b + {15'd0, pop[1]};
        end
    end
`endif
endmodule

// File: tb/tb_split_buf.sv
// tb_split_buf: randomized and directed stimulus for split_buf, checked by a queue-based scoreboard.
module tb_split_buf;
    localparam int W = 33;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0, s_sel = 1'b0, in_valid = 1'b0;
    logic         a_ready = 1'b0, b_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         s_ready, in_ready, a_valid, b_valid;
    logic [W-1:0] a_data, b_data;
`ifdef SPLIT_CNT_EN
    logic [15:0]  cnt_a, cnt_b;
    logic [15:0]  ca = '0, cb = '0;
`endif

    split_buf #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_sel(s_sel),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data)
`ifdef SPLIT_CNT_EN
        , .cnt_a(cnt_a), .cnt_b(cnt_b)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: select tokens pair in order with data tokens; each output is a bounded FIFO.
    logic [W-1:0] qa[$], qb[$];
    logic         selq[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_s_ready", s_ready, 1);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_a_valid", a_valid, 0);
            chk("rst_b_valid", b_valid, 0);
            chk("rst_a_data", a_data, 0);
            chk("rst_b_data", b_data, 0);
            qa.delete(); qb.delete(); selq.delete();
`ifdef SPLIT_CNT_EN
            chk("rst_cnt_a", cnt_a, 0);
            chk("rst_cnt_b", cnt_b, 0);
            ca = '0; cb = '0;
`endif
        end else begin
            automatic logic in_data_state = selq.size() != 0;
            automatic int   room = !in_data_state ? 0 : (selq[0] ? qb.size() : qa.size());
            automatic logic exp_ir = in_data_state && room < DEPTH;
            chk("a_valid", a_valid, qa.size() != 0);
            chk("b_valid", b_valid, qb.size() != 0);
            if (a_valid && qa.size() != 0) chk("a_data", a_data, qa[0]);
            if (b_valid && qb.size() != 0) chk("b_data", b_data, qb[0]);
            chk("in_ready", in_ready, exp_ir);
            chk("s_ready", s_ready, !in_data_state || (in_valid && exp_ir));
            if (a_valid && a_ready && qa.size() != 0) begin
                void'(qa.pop_front());
`ifdef SPLIT_CNT_EN
                ca++;
`endif
            end
            if (b_valid && b_ready && qb.size() != 0) begin
                void'(qb.pop_front());
`ifdef SPLIT_CNT_EN
                cb++;
`endif
            end
            if (in_valid && in_ready) begin
                if (selq.size() == 0) chk("data_without_sel", 1, 0);
                else if (selq.pop_front()) qb.push_back(in_data);
                else qa.push_back(in_data);
            end
            if (s_valid && s_ready) selq.push_back(s_sel);
        end
    end

    // Token stream driver: tsel/tdat hold tokens, si/di count accepted select/data tokens.
    logic         tsel[$];
    logic [W-1:0] tdat[$];
    int           si = 0, di = 0;
    int           ar_mode = 1, br_mode = 1;

    task automatic new_stream();
        tsel.delete(); tdat.delete(); si = 0; di = 0;
    endtask

    task automatic add(input logic s, input logic [W-1:0] d);
        tsel.push_back(s); tdat.push_back(d);
    endtask

    task automatic run(input int cycles, input int gap, output int used);
        logic sx, dx;
        used = 0;
        while (used < cycles && di < tsel.size()) begin
            s_valid  = si < tsel.size() && $urandom_range(99) >= gap;
            s_sel    = si < tsel.size() ? tsel[si] : 1'b0;
            in_valid = $urandom_range(99) >= gap;
            in_data  = tdat[di];
            a_ready  = ar_mode == 2 ? 1'($urandom_range(1)) : ar_mode[0];
            b_ready  = br_mode == 2 ? 1'($urandom_range(1)) : br_mode[0];
            @(negedge clk);
            sx = s_valid && s_ready;
            dx = in_valid && in_ready;
            @(posedge clk); #1;
            if (sx) si++;
            if (dx) di++;
            used++;
        end
        s_valid = 1'b0;
        in_valid = 1'b0;
        a_ready = ar_mode[0];
        b_ready = br_mode[0];
    endtask

    task automatic drain();
        ar_mode = 1; br_mode = 1; a_ready = 1; b_ready = 1;
        for (int c = 0; c < 100 && (qa.size() != 0 || qb.size() != 0); c++) @(posedge clk);
        @(posedge clk); #1;
        chk("drain_a_empty", qa.size(), 0);
        chk("drain_b_empty", qb.size(), 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("s_ready_after_release", s_ready, 1);
        @(posedge clk); #1;
    endtask

    int used;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("s_ready_after_release", s_ready, 1);
        @(posedge clk); #1;

        // single token to A
        new_stream(); ar_mode = 1; br_mode = 1;
        add(0, 33'h0_0000_00AA);
        run(10, 0, used);
        chk("t026_accepted", di, 1);
        drain();

        // back-to-back alternating selects, one token per cycle
        new_stream();
        add(1, 1); add(0, 2); add(1, 3);
        run(20, 0, used);
        chk("t027_cycles", used, 4);
        drain();

        // A stalled: two accepted, third held until a_ready rises
        new_stream(); ar_mode = 0;
        for (int i = 1; i <= 4; i++) add(0, W'(i));
        run(12, 0, used);
        chk("t028_accepted_stalled", di, 2);
        @(negedge clk);
        chk("t028_in_ready_held", in_ready, 0);
        @(posedge clk); #1;
        ar_mode = 1;
        run(40, 0, used);
        chk("t028_accepted_all", di, 4);
        drain();

        // A full and stalled, B token still passes
        new_stream(); ar_mode = 0; br_mode = 1;
        add(0, 33'h1_0000_0001); add(0, 33'h1_0000_0002); add(1, 33'h1_2345_6789);
        run(30, 0, used);
        chk("t029_accepted", di, 3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t029_a_stalled", a_valid, 1);
        chk("t029_b_delivered", b_valid, 0);
        @(posedge clk); #1;
        drain();

        // reset while A holds two tokens and a select is latched
        new_stream(); ar_mode = 0;
        add(0, 33'h0_1111_1111); add(0, 33'h0_2222_2222); add(0, 33'h0_3333_3333);
        run(10, 0, used);
        chk("t030_accepted_before_reset", di, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t030_a_valid_now", a_valid, 0);
        chk("t030_s_ready_now", s_ready, 1);
        chk("t030_in_ready_now", in_ready, 0);
        new_stream();
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("t030_s_ready_after_release", s_ready, 1);
        ar_mode = 1; a_ready = 1;
        repeat (5) @(posedge clk);
        #1;

        // random traffic with random gaps and backpressure
        new_stream(); ar_mode = 2; br_mode = 2;
        for (int i = 0; i < 300; i++) add(1'($urandom_range(1)), {1'($urandom_range(1)), 32'($urandom)});
        run(5000, 30, used);
        chk("random_accepted", di, 300);
        drain();

`ifdef SPLIT_CNT_EN
        pulse_reset();
        new_stream(); ar_mode = 1; br_mode = 1;
        for (int i = 0; i < 65537; i++) add(0, W'(i));
        run(70000, 0, used);
        chk("cnt_accepted", di, 65537);
        drain();
        chk("cnt_a_wrapped", cnt_a, 1);
        chk("cnt_b_zero", cnt_b, 0);
        chk("cnt_a_model", cnt_a, ca);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
